// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (F) and data (D).
// The winning request is registered onto the bus and held until iMemRdy or timeout.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        iClk,
  input  logic        nRst,
  input  logic        iReqF,
  input  logic [31:0] iAddrF,
  output logic        oDoneF,
  output logic [31:0] oRDataF,
  input  logic        iReqD,
  input  logic        iWriteD,
  input  logic [31:0] iAddrD,
  input  logic [31:0] iWDataD,
  output logic        oDoneD,
  output logic [31:0] oRDataD,
  output logic        oErr,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemData,
  output logic        oMemRead,
  output logic        oMemWrite,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          gnt_q, gnt_d;        // 1 = D granted
  logic          last_q, last_d;      // 1 = D won the previous grant
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_q, mem_data_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [31:0]   rdata_f_q, rdata_f_d;
  logic [31:0]   rdata_d_q, rdata_d_d;
  logic          done_f_q, done_f_d;
  logic          done_d_q, done_d_d;
  logic          err_q, err_d;
  logic          pick_d;
  logic          finish;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    rdata_f_d   = rdata_f_q;
    rdata_d_d   = rdata_d_q;
    done_f_d    = 1'b0;
    done_d_d    = 1'b0;
    err_d       = 1'b0;
    finish      = 1'b0;
    // On a tie the port opposite the previous winner takes the bus.
    pick_d      = iReqD & (~iReqF | ~last_q);

    case (state_q)
      IDLE: begin
        if (iReqF || iReqD) begin
          gnt_d       = pick_d;
          last_d      = pick_d;
          cnt_d       = '0;
          mem_addr_d  = pick_d ? iAddrD : iAddrF;
          mem_data_d  = pick_d ? iWDataD : '0;
          mem_write_d = pick_d & iWriteD;
          mem_read_d  = ~(pick_d & iWriteD);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (iMemRdy) begin
          finish = 1'b1;
          if (mem_read_q) begin
            if (gnt_q) rdata_d_d = iMemData;
            else       rdata_f_d = iMemData;
          end
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          finish = 1'b1;
          err_d  = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (finish) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          done_f_d    = ~gnt_q;
          done_d_d    = gnt_q;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rdata_f_q   <= '0;
      rdata_d_q   <= '0;
      done_f_q    <= 1'b0;
      done_d_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      rdata_f_q   <= rdata_f_d;
      rdata_d_q   <= rdata_d_d;
      done_f_q    <= done_f_d;
      done_d_q    <= done_d_d;
      err_q       <= err_d;
    end
  end

  assign oDoneF    = done_f_q;
  assign oDoneD    = done_d_q;
  assign oErr      = err_q;
  assign oRDataF   = rdata_f_q;
  assign oRDataD   = rdata_d_q;
  assign oMemAddr  = mem_addr_q;
  assign oMemData  = mem_data_q;
  assign oMemRead  = mem_read_q;
  assign oMemWrite = mem_write_q;

endmodule
